// File: rtl/calc_resp_checker.sv
// Passive multi-port scoreboard for the calculator: predicts each response from snooped
// requests, tracks outstanding (port, tag) entries and checks returned responses out of order.
module calc_resp_checker #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic                                  c_clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic [4*NUM_PORTS-1:0]                req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0]           req_data_in,
  input  logic [TAG_W*NUM_PORTS-1:0]            req_tag_in,
  input  logic [2*NUM_PORTS-1:0]                out_resp,
  input  logic [DATA_W*NUM_PORTS-1:0]           out_data,
  input  logic [TAG_W*NUM_PORTS-1:0]            out_tag,
  output logic [CNT_W-1:0]                      pass_cnt,
  output logic [CNT_W-1:0]                      fail_cnt,
  output logic [CNT_W-1:0]                      err_cnt,
  output logic [$clog2(NUM_PORTS*(2**TAG_W)):0] outstanding,
  output logic                                  idle,
  output logic                                  fail_seen,
  output logic [$clog2(NUM_PORTS)-1:0]          first_fail_port,
  output logic [TAG_W-1:0]                      first_fail_tag
);

  localparam int DEPTH   = 2**TAG_W;
  localparam int ENTRIES = NUM_PORTS*DEPTH;
  localparam int OUT_W   = $clog2(ENTRIES) + 1;
  localparam int PORT_W  = $clog2(NUM_PORTS);
  localparam int AGE_W   = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, OP2} state_t;

  state_t            state_q    [NUM_PORTS];
  state_t            state_d    [NUM_PORTS];
  logic [3:0]        cmd_q      [NUM_PORTS];
  logic [DATA_W-1:0] op1_q      [NUM_PORTS];
  logic [TAG_W-1:0]  tag_q      [NUM_PORTS];

  logic              valid_q    [ENTRIES];
  logic              valid_d    [ENTRIES];
  logic [1:0]        exp_resp_q [ENTRIES];
  logic [1:0]        exp_resp_d [ENTRIES];
  logic [DATA_W-1:0] exp_data_q [ENTRIES];
  logic [DATA_W-1:0] exp_data_d [ENTRIES];
  logic [AGE_W-1:0]  age_q      [ENTRIES];
  logic [AGE_W-1:0]  age_d      [ENTRIES];

  int                pass_inc;
  int                fail_inc;
  int                err_inc;
  int                valid_total;
  logic              all_idle;
  logic              ev_found;
  logic [PORT_W-1:0] ev_port;
  logic [TAG_W-1:0]  ev_tag;

  // Returns {resp, data}; data is only meaningful when resp is 1.
  function automatic logic [DATA_W+1:0] predict(input logic [3:0] cmd,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    sum  = {1'b0, a} + {1'b0, b};
    resp = 2'd2;
    data = '0;
    case (cmd)
      4'd1: if (!sum[DATA_W]) begin resp = 2'd1; data = sum[DATA_W-1:0]; end
      4'd2: if (b <= a) begin resp = 2'd1; data = a - b; end
      4'd5: begin resp = 2'd1; data = a << b[4:0]; end
      4'd6: begin resp = 2'd1; data = a >> b[4:0]; end
      default: ;
    endcase
    return {resp, data};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input int inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    logic [1:0]        rsp;
    logic [TAG_W-1:0]  rtag;
    logic [TAG_W-1:0]  port_tag;
    logic              port_ev;
    logic              hit;
    logic [DATA_W+1:0] pred;
    int                ridx;
    int                widx;
    int                idx;

    state_d     = state_q;
    valid_d     = valid_q;
    exp_resp_d  = exp_resp_q;
    exp_data_d  = exp_data_q;
    age_d       = age_q;
    pass_inc    = 0;
    fail_inc    = 0;
    err_inc     = 0;
    valid_total = 0;
    all_idle    = 1'b1;
    ev_found    = 1'b0;
    ev_port     = '0;
    ev_tag      = '0;
    rsp         = '0;
    rtag        = '0;
    port_tag    = '0;
    port_ev     = 1'b0;
    hit         = 1'b0;
    pred        = '0;
    ridx        = 0;
    widx        = 0;
    idx         = 0;

    for (int i = 0; i < ENTRIES; i++)
      if (valid_q[i]) age_d[i] = age_q[i] + AGE_W'(1);

    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp      = out_resp[2*p +: 2];
      rtag     = out_tag[TAG_W*p +: TAG_W];
      ridx     = p*DEPTH + int'(rtag);
      port_ev  = 1'b0;
      port_tag = rtag;

      // Retires look at the table as it stood before this cycle's write.
      if (rsp == 2'b11) begin
        err_inc       = err_inc + 1;
        port_ev       = 1'b1;
        valid_d[ridx] = 1'b0;
      end else if (rsp != 2'b00) begin
        if (!valid_q[ridx]) begin
          err_inc = err_inc + 1;
          port_ev = 1'b1;
        end else begin
          valid_d[ridx] = 1'b0;
          hit = (rsp == exp_resp_q[ridx]) &&
                (exp_resp_q[ridx] != 2'd1 || out_data[DATA_W*p +: DATA_W] == exp_data_q[ridx]);
          if (hit) pass_inc = pass_inc + 1;
          else begin
            fail_inc = fail_inc + 1;
            port_ev  = 1'b1;
          end
        end
      end

      for (int t = 0; t < DEPTH; t++) begin
        idx = p*DEPTH + t;
        if (valid_q[idx] && age_q[idx] == AGE_W'(TIMEOUT-1) &&
            !(rsp != 2'b00 && int'(rtag) == t)) begin
          valid_d[idx] = 1'b0;
          err_inc      = err_inc + 1;
          if (!port_ev) begin
            port_ev  = 1'b1;
            port_tag = TAG_W'(t);
          end
        end
      end

      case (state_q[p])
        IDLE: if (req_cmd_in[4*p +: 4] != 4'd0) state_d[p] = OP2;
        OP2: begin
          state_d[p] = IDLE;
          widx = p*DEPTH + int'(tag_q[p]);
          if (valid_d[widx]) begin
            err_inc = err_inc + 1;
            if (!port_ev) begin
              port_ev  = 1'b1;
              port_tag = tag_q[p];
            end
          end
          pred             = predict(cmd_q[p], op1_q[p], req_data_in[DATA_W*p +: DATA_W]);
          valid_d[widx]    = 1'b1;
          exp_resp_d[widx] = pred[DATA_W+1:DATA_W];
          exp_data_d[widx] = pred[DATA_W-1:0];
          age_d[widx]      = '0;
        end
      endcase

      if (state_d[p] != IDLE) all_idle = 1'b0;
      if (port_ev && !ev_found) begin
        ev_found = 1'b1;
        ev_port  = PORT_W'(p);
        ev_tag   = port_tag;
      end
    end

    for (int i = 0; i < ENTRIES; i++)
      if (valid_d[i]) valid_total = valid_total + 1;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= IDLE;
        cmd_q[p]   <= '0;
        op1_q[p]   <= '0;
        tag_q[p]   <= '0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]    <= 1'b0;
        exp_resp_q[i] <= '0;
        exp_data_q[i] <= '0;
        age_q[i]      <= '0;
      end
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      err_cnt         <= '0;
      outstanding     <= '0;
      idle            <= 1'b1;
      fail_seen       <= 1'b0;
      first_fail_port <= '0;
      first_fail_tag  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      exp_resp_q <= exp_resp_d;
      exp_data_q <= exp_data_d;
      age_q      <= age_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (state_q[p] == IDLE && req_cmd_in[4*p +: 4] != 4'd0) begin
          cmd_q[p] <= req_cmd_in[4*p +: 4];
          op1_q[p] <= req_data_in[DATA_W*p +: DATA_W];
          tag_q[p] <= req_tag_in[TAG_W*p +: TAG_W];
        end
      end
      outstanding <= OUT_W'(valid_total);
      idle        <= (valid_total == 0) && all_idle;
      if (clear) begin
        pass_cnt        <= '0;
        fail_cnt        <= '0;
        err_cnt         <= '0;
        fail_seen       <= 1'b0;
        first_fail_port <= '0;
        first_fail_tag  <= '0;
      end else begin
        pass_cnt <= sat_add(pass_cnt, pass_inc);
        fail_cnt <= sat_add(fail_cnt, fail_inc);
        err_cnt  <= sat_add(err_cnt, err_inc);
        if (!fail_seen && ev_found) begin
          fail_seen       <= 1'b1;
          first_fail_port <= ev_port;
          first_fail_tag  <= ev_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_resp_checker.sv
// Directed bench playing the calculator around calc_resp_checker; a queue of predicted
// responses decides whether each returned response should count as pass, fail or error.
module tb_calc_resp_checker;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int TO = 64;
  localparam int CW = 16;

  logic            c_clk = 1'b0;
  logic            reset;
  logic            clear;
  logic [4*NP-1:0] req_cmd_in;
  logic [DW*NP-1:0] req_data_in;
  logic [TW*NP-1:0] req_tag_in;
  logic [2*NP-1:0] out_resp;
  logic [DW*NP-1:0] out_data;
  logic [TW*NP-1:0] out_tag;
  logic [CW-1:0]   pass_cnt;
  logic [CW-1:0]   fail_cnt;
  logic [CW-1:0]   err_cnt;
  logic [4:0]      outstanding;
  logic            idle;
  logic            fail_seen;
  logic [1:0]      first_fail_port;
  logic [TW-1:0]   first_fail_tag;

  typedef struct {
    int         port;
    int         tag;
    logic [1:0] resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_pass = 0;
  int   exp_fail = 0;
  int   exp_err  = 0;

  always #5 c_clk = ~c_clk;

  calc_resp_checker #(
    .NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .c_clk(c_clk), .reset(reset), .clear(clear),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_cnt(err_cnt),
    .outstanding(outstanding), .idle(idle), .fail_seen(fail_seen),
    .first_fail_port(first_fail_port), .first_fail_tag(first_fail_tag)
  );

  function automatic exp_t model(input int port, input int tag, input logic [3:0] cmd,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      s;
    logic [4:0]  sh;
    e.port = port;
    e.tag  = tag;
    e.resp = 2'd2;
    e.data = '0;
    sh     = b[4:0];
    s      = longint'(a) + longint'(b);
    case (cmd)
      4'd1: if (s < 64'h1_0000_0000) begin e.resp = 2'd1; e.data = a + b; end
      4'd2: if (a >= b) begin e.resp = 2'd1; e.data = a - b; end
      4'd5: begin e.resp = 2'd1; e.data = a << sh; end
      4'd6: begin e.resp = 2'd1; e.data = a >> sh; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
      end
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, "_pass"}, 32'(pass_cnt), exp_pass);
    checkOutput({name, "_fail"}, 32'(fail_cnt), exp_fail);
    checkOutput({name, "_err"},  32'(err_cnt),  exp_err);
  endtask

  // Two-cycle request on every port in mask; tags holds a TW-bit tag per port.
  task automatic applyStimulus(input logic [NP-1:0] mask, input logic [3:0] cmd,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [TW*NP-1:0] tags);
    int t;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        t = int'(tags[TW*p +: TW]);
        req_cmd_in[4*p +: 4]   = cmd;
        req_data_in[DW*p +: DW] = op1;
        req_tag_in[TW*p +: TW] = tags[TW*p +: TW];
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].port == p && sb[i].tag == t) begin
            sb.delete(i);
            exp_err++;
          end
        end
        sb.push_back(model(p, t, cmd, op1, op2));
      end
    end
    tick();
    req_cmd_in = '0;
    for (int p = 0; p < NP; p++)
      if (mask[p]) req_data_in[DW*p +: DW] = op2;
    tick();
    req_data_in = '0;
    req_tag_in  = '0;
  endtask

  // One response cycle on a single port, scored against the queue.
  task automatic respond(input int port, input logic [1:0] rsp, input logic [31:0] data,
                         input int tag);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].port == port && sb[i].tag == tag) idx = i;
    if (rsp == 2'b11) begin
      exp_err++;
      if (idx >= 0) sb.delete(idx);
    end else if (idx < 0) begin
      exp_err++;
    end else begin
      if (rsp == sb[idx].resp && (sb[idx].resp != 2'd1 || data == sb[idx].data)) exp_pass++;
      else exp_fail++;
      sb.delete(idx);
    end
    out_resp[2*port +: 2]   = rsp;
    out_data[DW*port +: DW] = data;
    out_tag[TW*port +: TW]  = TW'(tag);
    tick();
    out_resp = '0;
    out_data = '0;
    out_tag  = '0;
  endtask

  task automatic clearPulse();
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    exp_err  = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    clear       = 1'b0;
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    out_resp    = '0;
    out_data    = '0;
    out_tag     = '0;
    tick();
    tick();
    checkCounters("reset");
    checkOutput("reset_outstanding", 32'(outstanding), 0);
    checkOutput("reset_idle", 32'(idle), 1);
    checkOutput("reset_fail_seen", 32'(fail_seen), 0);
    checkOutput("reset_ff_port", 32'(first_fail_port), 0);
    checkOutput("reset_ff_tag", 32'(first_fail_tag), 0);
    reset = 1'b0;
    tick();

    $display("[TB] add on port 0, in-order response");
    applyStimulus(4'b0001, 4'd1, 32'h56, 32'h103, 8'h00);
    checkOutput("add_outstanding", 32'(outstanding), 1);
    checkOutput("add_idle_busy", 32'(idle), 0);
    respond(0, 2'd1, 32'h159, 0);
    checkCounters("add");
    checkOutput("add_pass_lit", 32'(pass_cnt), 1);
    checkOutput("add_outstanding_done", 32'(outstanding), 0);
    checkOutput("add_idle_done", 32'(idle), 1);

    $display("[TB] sub on all ports, reversed responses");
    clearPulse();
    checkCounters("clear");
    applyStimulus(4'b1111, 4'd2, 32'h158, 32'h12, 8'hE4);
    checkOutput("sub_outstanding", 32'(outstanding), 4);
    for (int t = 3; t >= 0; t--) respond(t, 2'd1, 32'h146, t);
    checkCounters("sub");
    checkOutput("sub_pass_lit", 32'(pass_cnt), 4);
    checkOutput("sub_outstanding_done", 32'(outstanding), 0);

    $display("[TB] add overflow answered as success");
    clearPulse();
    applyStimulus(4'b0010, 4'd1, 32'hFFFF_FFFF, 32'd1, 8'h08);
    respond(1, 2'd1, 32'h0, 2);
    checkCounters("ovf");
    checkOutput("ovf_fail_lit", 32'(fail_cnt), 1);
    checkOutput("ovf_fail_seen", 32'(fail_seen), 1);
    checkOutput("ovf_ff_port", 32'(first_fail_port), 1);
    checkOutput("ovf_ff_tag", 32'(first_fail_tag), 2);

    $display("[TB] shift left then unissued tag");
    clearPulse();
    checkOutput("clear_fail_seen", 32'(fail_seen), 0);
    applyStimulus(4'b0100, 4'd5, 32'h1, 32'h24, 8'h10);
    respond(2, 2'd1, 32'h10, 1);
    respond(2, 2'd1, 32'h10, 3);
    checkCounters("shl");
    checkOutput("shl_err_lit", 32'(err_cnt), 1);
    checkOutput("shl_ff_port", 32'(first_fail_port), 2);
    checkOutput("shl_ff_tag", 32'(first_fail_tag), 3);

    $display("[TB] simultaneous errors on ports 3 and 1");
    clearPulse();
    out_resp[7:6] = 2'd1;
    out_tag[7:6]  = 2'd0;
    out_resp[3:2] = 2'd1;
    out_tag[3:2]  = 2'd2;
    exp_err += 2;
    tick();
    out_resp = '0;
    out_tag  = '0;
    checkCounters("multi");
    checkOutput("multi_ff_port", 32'(first_fail_port), 1);
    checkOutput("multi_ff_tag", 32'(first_fail_tag), 2);

    $display("[TB] withheld response times out");
    clearPulse();
    applyStimulus(4'b0001, 4'd6, 32'h80, 32'd3, 8'h01);
    repeat (TO - 1) tick();
    checkOutput("to_err_before", 32'(err_cnt), 0);
    checkOutput("to_outstanding_before", 32'(outstanding), 1);
    tick();
    sb.delete();
    exp_err++;
    checkCounters("to");
    checkOutput("to_outstanding_after", 32'(outstanding), 0);
    checkOutput("to_ff_port", 32'(first_fail_port), 0);
    checkOutput("to_ff_tag", 32'(first_fail_tag), 1);
    checkOutput("to_idle", 32'(idle), 1);

    $display("[TB] tag reuse overwrites the entry");
    clearPulse();
    applyStimulus(4'b1000, 4'd6, 32'h80, 32'd3, 8'h80);
    applyStimulus(4'b1000, 4'd5, 32'h3, 32'd2, 8'h80);
    checkOutput("reuse_outstanding", 32'(outstanding), 1);
    checkOutput("reuse_ff_port", 32'(first_fail_port), 3);
    respond(3, 2'd1, 32'hC, 2);
    checkCounters("reuse");

    $display("[TB] reset with entries outstanding");
    clearPulse();
    respond(3, 2'd1, 32'h0, 3);
    applyStimulus(4'b0111, 4'd1, 32'h1, 32'h2, 8'h00);
    checkOutput("rst3_outstanding", 32'(outstanding), 3);
    reset = 1'b1;
    tick();
    sb.delete();
    exp_pass = 0;
    exp_fail = 0;
    exp_err  = 0;
    checkCounters("rst3");
    checkOutput("rst3_outstanding_after", 32'(outstanding), 0);
    checkOutput("rst3_idle", 32'(idle), 1);
    checkOutput("rst3_fail_seen", 32'(fail_seen), 0);
    reset = 1'b0;
    tick();
    respond(0, 2'd1, 32'h3, 0);
    checkCounters("stale");
    checkOutput("stale_err_lit", 32'(err_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_resp_checker.md
Name: calc_resp_checker

Overview:
- Synthesizable, parametrised scoreboard that passively snoops all request/response ports of the calculator DUT.
- Computes the expected response per request, tracks outstanding tags per port, and compares each returned response against it.
- Replaces per-port, single-shot checking in the bench with multi-port, multi-tag, out-of-order checking plus timeout detection.
- Instantiated beside calc2_top in the bench, on the same interface signals.

Parameters:
- NUM_PORTS, 4, number of request/response port pairs monitored.
- DATA_W, 32, operand/result width.
- TAG_W, 2, tag width; 2**TAG_W outstanding entries per port.
- TIMEOUT, 64, cycles an entry may stay outstanding before it is flagged.
- CNT_W, 16, width of the statistics counters.

Ports:
- c_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of counters and first-fail capture; table untouched.
- req_cmd_in  in  4*NUM_PORTS  per-port command, port p at [4p+3:4p].
- req_data_in  in  DATA_W*NUM_PORTS  per-port operand bus.
- req_tag_in  in  TAG_W*NUM_PORTS  per-port request tag.
- out_resp  in  2*NUM_PORTS  DUT response code per port.
- out_data  in  DATA_W*NUM_PORTS  DUT result per port.
- out_tag  in  TAG_W*NUM_PORTS  DUT response tag per port.
- pass_cnt  out  CNT_W  matching responses.
- fail_cnt  out  CNT_W  mismatching responses.
- err_cnt  out  CNT_W  protocol errors: unexpected tag, tag reuse, timeout, resp 2'b11.
- outstanding  out  $clog2(NUM_PORTS*2**TAG_W)+1  valid table entries.
- idle  out  1  outstanding==0 and every port FSM is in IDLE.
- fail_seen  out  1  sticky; set on first fail or error.
- first_fail_port  out  $clog2(NUM_PORTS)  port of the first fail or error.
- first_fail_tag  out  TAG_W  tag of the first fail or error.

Behaviour:
- Reset:
  - All counters 0.
  - outstanding 0, idle 1.
  - fail_seen, first_fail_port and first_fail_tag all 0.
  - All table entries invalid; all FSMs in IDLE.
- Request protocol (per port):
  - Command cycle: cmd != 0, data carries op1, tag carries the tag.
  - Next cycle: data carries op2.
- Per-port FSM:
  - IDLE: cmd != 0 latches cmd, op1 and tag, then moves to OP2.
  - OP2: latches op2, writes the entry, returns to IDLE. cmd is ignored in OP2.
- Expected model:
  - 1 (add): sum = op1 + op2 at DATA_W+1 bits; carry -> resp 2, else resp 1 with data sum[DATA_W-1:0].
  - 2 (sub): op2 > op1 -> resp 2, else resp 1 with data op1 - op2.
  - 5 (shl): resp 1, data op1 << op2[4:0].
  - 6 (shr): resp 1, data op1 >> op2[4:0].
  - Any other nonzero cmd: resp 2.
- Table entry per (port, tag): valid, exp_resp, exp_data, age.
  - Write at OP2 completion sets age 0.
  - If valid is already set: err_cnt+1, entry overwritten.
- Response handling, whenever out_resp != 0 on a port:
  - Look up (port, out_tag). Not valid -> err_cnt+1.
  - Valid: compare out_resp, plus out_data only when exp_resp==1. Match -> pass_cnt+1, else fail_cnt+1. Entry retired.
  - out_resp==2'b11 -> err_cnt+1 and entry retired.
- Same (port, tag) retired and written in one cycle: retire evaluated first against the old contents, then the write lands; net valid=1.
- Ageing:
  - Each valid entry's age increments every cycle.
  - When age reaches TIMEOUT-1 and no response arrives that cycle: entry retired, err_cnt+1.
- Counters:
  - Several ports may hit in one cycle; each counter adds the count of events that cycle.
  - Counters saturate at all-ones.
- first_fail capture: only while fail_seen==0. Among simultaneous events, the lowest port index wins.
- Output timing: all outputs registered; counters reflect an event one cycle after its response cycle.
- reset has priority over clear. Reset mid-transaction drops all entries silently (no error counted).

Test Plan:
- Port 1, cmd 1, op1 0x56, op2 0x103, tag 0; DUT returns resp 1, data 0x159, tag 0 -> pass_cnt=1, outstanding back to 0, idle=1.
- All 4 ports, cmd 2, op1 0x158, op2 0x12, tags 0..3, responses returned in reversed tag order -> pass_cnt=4, fail_cnt=0.
- Port 2, cmd 1, op1 0xFFFFFFFF, op2 1; DUT returns resp 1, data 0 -> fail_cnt=1, fail_seen=1, first_fail_port=1, first_fail_tag=tag used.
- Port 3, cmd 5, op1 1, op2 0x24; expected resp 1, data 0x10 (shift by 4). Then a response with unissued tag 3 -> err_cnt=1.
- Issue a request and withhold the response for TIMEOUT cycles -> err_cnt=1 exactly after TIMEOUT cycles, outstanding=0.
- Assert reset with 3 entries outstanding -> outstanding=0, counters 0, idle=1 the next cycle; a later response with the old tag -> err_cnt=1.
